clock_display_ctrl: RTL and testbench
=====================================

// Module: clock_display_ctrl
// PURPOSE
//  Timekeeping and display sequencer for the 4-digit HH:MM clock on the HEX displays.
//  Keeps BCD time HH:MM:SS and runs a RUN / SET_HR / SET_MIN mode FSM driven by key pulses.
//  Drives the number and enable inputs of four sevenSegDisplay instances.
//  Blinks the field being set; optionally blanks a leading hour zero.
// PARAMETERS
//  BLINK_DIV  12_500_000  clk cycles per blink half-period (2 Hz at 50 MHz); must be >= 2
//  LZ_BLANK   1           1 = blank the hour-tens digit when it is 0
// PORTS
//  clk        in   1   system clock; sole clock domain
//  rst        in   1   synchronous, active-high reset
//  tick_sec   in   1   one-clk pulse once per second, from an external prescaler
//  key_mode   in   1   one-clk pulse (debounced) that advances the mode
//  key_inc    in   1   one-clk pulse (debounced) that increments the selected field
//  digit_num  out  16  {h10,h1,m10,m1}; 4-bit BCD per digit, to decoder number inputs
//  digit_en   out  4   {h10,h1,m10,m1} enables, to decoder enable inputs
//  mode       out  2   0=RUN, 1=SET_HR, 2=SET_MIN (3 is unused and never produced)
//  colon      out  1   seconds indicator (LED)
// BEHAVIOUR
//  - All outputs are registered. An input sampled at edge N appears on the outputs after edge N.
//  - Reset values:
//    - time 00:00:00, mode=0, blink_phase=1, blink counter=0
//    - digit_num=16'h0000, digit_en=LZ_BLANK?4'b0111:4'b1111, colon=1
//  - Mode FSM:
//    - key_mode moves RUN->SET_HR->SET_MIN->RUN.
//    - On the SET_MIN->RUN transition, seconds are cleared to 00.
//  - RUN mode:
//    - tick_sec increments ss.
//    - 59 s carries into mm; 59 min carries into hh; 23:59:59 wraps to 00:00:00.
//    - key_inc is ignored.
//  - SET modes:
//    - tick_sec is ignored; time is frozen.
//    - key_inc in SET_HR: hh+1, 23 wraps to 00.
//    - key_inc in SET_MIN: mm+1, 59 wraps to 00, with no carry into hh.
//  - Simultaneous key_mode and key_inc: key_mode wins and the increment is discarded.
//  - BCD legality: h10<=2, h1<=9 (h1<=3 when h10=2), m10/s10<=5, m1/s1<=9. No other codes reachable.
//  - Blink:
//    - Counter runs 0..BLINK_DIV-1 in all modes; blink_phase toggles on wrap.
//    - Any mode change or accepted key_inc reloads counter=0, blink_phase=1 (field visible).
//  - digit_en:
//    - RUN: all digits on.
//    - SET_HR: bits[3:2]=blink_phase, bits[1:0]=1.
//    - SET_MIN: bits[1:0]=blink_phase, bits[3:2]=1.
//    - Then, if LZ_BLANK and h10==0, bit3 is forced to 0.
//  - colon: RUN = ~s1[0] (on during even seconds); SET modes = 1.
//  - rst overrides everything in the same edge, including mid-set and with a concurrent tick or key.
// TESTING
//  1. Release rst -> digit_num=16'h0000, digit_en=4'b0111, mode=0, colon=1.
//  2. mode; inc x23; mode; inc x59; mode -> digit_num=16'h2359, mode=0.
//     Then 60 tick_sec -> 16'h0000, digit_en=4'b0111.
//  3. SET_HR at 23:45, inc -> digit_num=16'h0045. SET_MIN at 00:59, inc -> 16'h0000 (hh unchanged).
//  4. BLINK_DIV=4, SET_MIN at 12:34, idle:
//     - digit_en[1:0] toggles 11/00 every 4 clk; digit_en[3:2]=11.
//     - An inc mid-off-phase -> 11 on the next edge.
//  5. SET_HR with key_mode & key_inc on the same clk -> mode=2, hours unchanged.
//     tick_sec x5 in SET mode -> ss unchanged.
//  6. rst pulsed in SET_MIN together with key_inc and tick_sec -> all reset values after that edge.

Source files
------------

// File: rtl/clock_display_ctrl.sv
// HH:MM:SS BCD timekeeper with RUN / SET_HR / SET_MIN mode sequencing and
// blink/blanking control for a four-digit seven-segment HH:MM display.
module clock_display_ctrl #(
    parameter int BLINK_DIV = 12_500_000,
    parameter bit LZ_BLANK  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_sec,
    input  logic        key_mode,
    input  logic        key_inc,
    output logic [15:0] digit_num,
    output logic [3:0]  digit_en,
    output logic [1:0]  mode,
    output logic        colon
);

    localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_e;

    // Increment a 00..59 BCD pair; bit 8 of the result is the carry out of 59.
    function automatic logic [8:0] sexa_inc(input logic [7:0] v);
        logic [8:0] r;
        if (v[3:0] != 4'd9) begin
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        end else if (v[7:4] != 4'd5) begin
            r = {1'b0, v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {1'b1, 8'h00};
        end
        return r;
    endfunction

    // Increment a 00..23 BCD hour pair, wrapping 23 to 00.
    function automatic logic [7:0] hour_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    mode_e          mode_q, mode_d;
    logic [7:0]     hh_q, hh_d;
    logic [7:0]     mm_q, mm_d;
    logic [7:0]     ss_q, ss_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           phase_q, phase_d;
    logic [3:0]     en_q, en_d;
    logic           colon_q, colon_d;
    logic           reload_s;
    logic [8:0]     ss_inc_s;
    logic [8:0]     mm_inc_s;
    logic [8:0]     mm_set_s;

    assign ss_inc_s = sexa_inc(ss_q);
    assign mm_inc_s = sexa_inc(mm_q);
    assign mm_set_s = sexa_inc(mm_q);

    // Mode FSM and time update; key_mode takes priority over key_inc.
    always_comb begin
        mode_d   = mode_q;
        hh_d     = hh_q;
        mm_d     = mm_q;
        ss_d     = ss_q;
        reload_s = 1'b0;
        if (key_mode) begin
            reload_s = 1'b1;
            case (mode_q)
                MODE_RUN:     mode_d = MODE_SET_HR;
                MODE_SET_HR:  mode_d = MODE_SET_MIN;
                MODE_SET_MIN: begin
                    mode_d = MODE_RUN;
                    ss_d   = 8'h00;
                end
                default:      mode_d = MODE_RUN;
            endcase
        end else if (key_inc) begin
            case (mode_q)
                MODE_SET_HR: begin
                    hh_d     = hour_inc(hh_q);
                    reload_s = 1'b1;
                end
                MODE_SET_MIN: begin
                    mm_d     = mm_set_s[7:0];
                    reload_s = 1'b1;
                end
                default: begin
                    reload_s = 1'b0;
                end
            endcase
        end else begin
            reload_s = 1'b0;
        end

        if (tick_sec && (mode_q == MODE_RUN)) begin
            ss_d = ss_inc_s[7:0];
            if (ss_inc_s[8]) begin
                mm_d = mm_inc_s[7:0];
                if (mm_inc_s[8]) begin
                    hh_d = hour_inc(hh_q);
                end else begin
                    hh_d = hh_q;
                end
            end else begin
                mm_d = mm_q;
            end
        end else begin
            ss_d = ss_d;
        end
    end

    // Blink timebase; a reload makes the field being set visible immediately.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (reload_s) begin
            cnt_d   = {CW{1'b0}};
            phase_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = {CW{1'b0}};
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Digit enables and colon derived from next-state values so outputs track the same edge.
    always_comb begin
        en_d    = 4'b1111;
        colon_d = 1'b1;
        case (mode_d)
            MODE_RUN: begin
                en_d    = 4'b1111;
                colon_d = ~ss_d[0];
            end
            MODE_SET_HR: begin
                en_d    = {phase_d, phase_d, 2'b11};
                colon_d = 1'b1;
            end
            MODE_SET_MIN: begin
                en_d    = {2'b11, phase_d, phase_d};
                colon_d = 1'b1;
            end
            default: begin
                en_d    = 4'b1111;
                colon_d = 1'b1;
            end
        endcase
        if (LZ_BLANK && (hh_d[7:4] == 4'd0)) begin
            en_d[3] = 1'b0;
        end else begin
            en_d[3] = en_d[3];
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_RUN;
            hh_q    <= 8'h00;
            mm_q    <= 8'h00;
            ss_q    <= 8'h00;
            cnt_q   <= {CW{1'b0}};
            phase_q <= 1'b1;
            en_q    <= LZ_BLANK ? 4'b0111 : 4'b1111;
            colon_q <= 1'b1;
        end else begin
            mode_q  <= mode_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            en_q    <= en_d;
            colon_q <= colon_d;
        end
    end

    assign digit_num = {hh_q, mm_q};
    assign digit_en  = en_q;
    assign mode      = mode_q;
    assign colon     = colon_q;

endmodule

// File: tb/tb_clock_display_ctrl.sv
// Directed plus randomized bench for clock_display_ctrl against a
// seconds-of-day reference model.
module tb_clock_display_ctrl;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_sec = 1'b0;
    logic        key_mode = 1'b0;
    logic        key_inc = 1'b0;
    logic [15:0] digit_num;
    logic [3:0]  digit_en;
    logic [1:0]  mode;
    logic        colon;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int hh = 0, mm = 0, ss = 0, md = 0, bc = 0, bp = 1;

    clock_display_ctrl #(.BLINK_DIV(DIV), .LZ_BLANK(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_sec  (tick_sec),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .digit_num (digit_num),
        .digit_en  (digit_en),
        .mode      (mode),
        .colon     (colon)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit km, input bit ti, input bit ki);
        int pm;
        int tod;
        bit reload;
        if (r) begin
            hh = 0; mm = 0; ss = 0; md = 0; bc = 0; bp = 1;
        end else begin
            pm = md;
            reload = 1'b0;
            if (km) begin
                if (md == 2) ss = 0;
                md = (md + 1) % 3;
                reload = 1'b1;
            end else if (ki && md == 1) begin
                hh = (hh + 1) % 24;
                reload = 1'b1;
            end else if (ki && md == 2) begin
                mm = (mm + 1) % 60;
                reload = 1'b1;
            end
            if (ti && pm == 0) begin
                tod = (hh * 3600 + mm * 60 + ss + 1) % 86400;
                hh = tod / 3600;
                mm = (tod / 60) % 60;
                ss = tod % 60;
            end
            if (reload) begin
                bc = 0; bp = 1;
            end else if (bc == DIV - 1) begin
                bc = 0; bp = 1 - bp;
            end else begin
                bc = bc + 1;
            end
        end
    endtask

    function automatic logic [15:0] exp_num();
        logic [15:0] e;
        e[15:12] = 4'(hh / 10);
        e[11:8]  = 4'(hh % 10);
        e[7:4]   = 4'(mm / 10);
        e[3:0]   = 4'(mm % 10);
        return e;
    endfunction

    function automatic logic [3:0] exp_en();
        logic [3:0] e;
        logic p;
        p = (bp != 0);
        if (md == 1)      e = {p, p, 2'b11};
        else if (md == 2) e = {2'b11, p, p};
        else              e = 4'b1111;
        if (hh < 10) e[3] = 1'b0;
        return e;
    endfunction

    task automatic cycle(input bit r, input bit km, input bit ti, input bit ki);
        rst = r; key_mode = km; tick_sec = ti; key_inc = ki;
        @(posedge clk);
        model_step(r, km, ti, ki);
        #1;
        rst = 1'b0; key_mode = 1'b0; tick_sec = 1'b0; key_inc = 1'b0;
        chk("num", digit_num, exp_num());
        chk("en", {12'h000, digit_en}, {12'h000, exp_en()});
        chk("mode", {14'h0000, mode}, 16'(md));
        chk("colon", {15'h0000, colon}, (md == 0) ? 16'((ss % 10) % 2 == 0) : 16'h0001);
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        // 1: reset state
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_num", digit_num, 16'h0000);
        chk("rst_en", {12'h000, digit_en}, 16'h0007);

        // 2: set 23:59, then roll over with 60 ticks
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        incs(23);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        incs(59);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("set_2359", digit_num, 16'h2359);
        chk("run_mode", {14'h0000, mode}, 16'h0000);
        for (int i = 0; i < 60; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("wrap_num", digit_num, 16'h0000);
        chk("wrap_en", {12'h000, digit_en}, 16'h0007);

        // 3: hour wrap and minute wrap without carry
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        incs(23);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        incs(45);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        incs(1);
        chk("hr_wrap", digit_num, 16'h0045);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        incs(14);
        chk("min_59", digit_num, 16'h0059);
        incs(1);
        chk("min_wrap", digit_num, 16'h0000);

        // 4: blink in SET_MIN at 12:34
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        incs(12);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        incs(34);
        chk("set_1234", digit_num, 16'h1234);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20 && digit_en[1:0] != 2'b00; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("blink_off", {12'h000, digit_en}, 16'h000C);
        incs(1);
        chk("blink_reload", {12'h000, digit_en}, 16'h000F);

        // 5: simultaneous keys in SET_HR, then ticks ignored in SET_MIN
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        chk("both_mode", {14'h0000, mode}, 16'h0002);
        chk("both_hr", digit_num, 16'h1235);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("frozen", digit_num, 16'h1235);

        // 6: reset with concurrent tick and inc in SET_MIN
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        chk("rst_mid_num", digit_num, 16'h0000);
        chk("rst_mid_en", {12'h000, digit_en}, 16'h0007);
        chk("rst_mid_mode", {14'h0000, mode}, 16'h0000);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
